id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Sits directly downstream of the main opcode decoder. It registers the decoder's control bundle and the ID-stage operands into the ID/EX pipeline register, and detects load-use hazards against the instruction currently in EX. On a hazard it stalls PC and IF/ID and injects a bubble. It squashes the ID-stage instruction on a taken-branch/jump flush and counts inserted bubbles for debug.

Parameters:
DATA_W, 32, width of register operands, sign-extended immediate and PC+4
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash ID-stage instruction (taken branch/jump resolved downstream)
id_opcode  in  6  instruction[31:26] of the ID-stage instruction
id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoder control outputs
id_aluop  in  2  decoder ALU op
id_rd1, id_rd2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4
id_rs, id_rt, id_rd  in  5  register specifiers
id_funct  in  6  instruction[5:0]
stall  out  1  1 = hold PC and IF/ID this cycle
ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control
ex_aluop  out  2  registered ALU op
ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered data
ex_rs, ex_rt, ex_rd  out  5  registered specifiers
ex_funct  out  6  registered funct
ex_valid  out  1  1 = EX holds a real instruction, 0 = bubble/squash
bubble_cnt  out  CNT_W  saturating count of hazard bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. stall is combinational and reads 0 because ex_memread = 0. When rst_n is deasserted mid-stream, the first post-reset edge captures normally.
- uses_rs = (id_opcode != 6'b000010). uses_rt = id_opcode is 6'b000000, 6'b000100 or 6'b101011.
- hazard (combinational) = ex_valid & ex_memread & ex_regwrite & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- stall = hazard & ~flush. It is combinational, with no latency.
- Per rising edge, priority is flush > hazard > normal:
  - flush=1: all ex_* control bits = 0, ex_valid = 0. Data/specifier fields still load from id_* (don't-care). bubble_cnt unchanged.
  - hazard=1 (no flush): all ex_* control bits = 0, ex_valid = 0. Data fields load from id_* (don't-care). bubble_cnt += 1, saturating at all-ones.
  - otherwise: every ex_* = corresponding id_* (1-cycle latency), ex_valid = 1.
- A load-use stall lasts exactly one cycle. After the bubble, ex_memread = 0, so hazard drops and the held instruction advances on the next edge.
- Two back-to-back loads feeding each other produce one bubble per dependent pair, never two consecutive bubbles for one instruction.
- Bubble control values are all-zero by definition. X values from the decoder never reach EX during a bubble or squash.
- No dependence is raised on $0 (ex_rt == 0), even if a load targets $0.
- ex_rd1/ex_rd2 carry no forwarding. Forwarding is the EX-stage unit's job.

Test Plan:
- Reset: hold rst_n=0 with random id_* and toggling clk -> all ex_* = 0, ex_valid = 0, stall = 0, bubble_cnt = 0. Release rst_n; R-type opcode 000000 with rd1=32'h5, rd2=32'h7 -> next edge ex_regwrite = 1, ex_aluop = 2'b10, ex_rd1 = 5, ex_valid = 1.
- Load-use on rt: lw rt=8 in EX; ID holds R-type rs=9, rt=8 -> stall = 1 that cycle; next edge ex_valid = 0 with all control 0, bubble_cnt = 1; following cycle stall = 0 and the R-type enters EX.
- Load-use masks: lw rt=8 in EX; ID holds lw rs=3, rt=8 -> stall = 0 (rt not used). lw rt=0 in EX; ID holds R-type rs=0 -> stall = 0. ID holds j (000010) with rs field = 8 -> stall = 0.
- Flush beats hazard: lw rt=8 in EX, ID beq rs=8, flush = 1 -> stall = 0; next edge ex_valid = 0, ex_branch = 0, bubble_cnt unchanged.
- Saturation: with CNT_W=2, force 5 hazard bubbles -> bubble_cnt sequence 1, 2, 3, 3, 3.
- Async reset mid-stall: assert rst_n=0 between edges while stall = 1 -> ex_* clear immediately with no clock edge, and stall drops to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures the main decoder's control bundle and the ID-stage operands on every
// rising edge. When the instruction in EX is a load whose destination feeds a
// source of the ID-stage instruction, the stage raises stall (hold PC and IF/ID)
// and inserts a bubble. A flush squashes the ID-stage instruction instead.
// Inserted hazard bubbles are counted for debug in a saturating counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               squash the ID-stage instruction this edge
//   id_*                decoder controls, operands and specifiers from ID
//   stall               combinational: hold PC and IF/ID this cycle
//   ex_*                registered controls, operands and specifiers for EX
//   ex_valid            1 = EX holds a real instruction, 0 = bubble/squash
//   bubble_cnt          saturating count of hazard bubbles inserted
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [5:0]        id_opcode,
   input  logic              id_regdst,
   input  logic              id_branch,
   input  logic              id_memread,
   input  logic              id_memtoreg,
   input  logic              id_memwrite,
   input  logic              id_alusrc,
   input  logic              id_regwrite,
   input  logic [1:0]        id_aluop,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [5:0]        id_funct,
   output logic              stall,
   output logic              ex_regdst,
   output logic              ex_branch,
   output logic              ex_memread,
   output logic              ex_memtoreg,
   output logic              ex_memwrite,
   output logic              ex_alusrc,
   output logic              ex_regwrite,
   output logic [1:0]        ex_aluop,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [5:0]        ex_funct,
   output logic              ex_valid,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpSw    = 6'b101011;

   logic uses_rs;
   logic uses_rt;
   logic hazard;
   logic bubble;

   // Only j ignores rs; rt is a real source for R-type, beq and sw (for lw and
   // I-type ALU ops it is the destination, so it must not raise a dependence).
   always_comb begin
      uses_rs = (id_opcode != OpJ);
      uses_rt = (id_opcode == OpRType) || (id_opcode == OpBeq) || (id_opcode == OpSw);
      hazard  = ex_valid & ex_memread & ex_regwrite & (ex_rt != 5'd0) &
                ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));
      stall   = hazard & ~flush;
      bubble  = flush | hazard;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_regdst   <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_pc4      <= '0;
         ex_rs       <= 5'd0;
         ex_rt       <= 5'd0;
         ex_rd       <= 5'd0;
         ex_funct    <= 6'd0;
         ex_valid    <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         // Data and specifiers load unconditionally; they are don't-care in a
         // bubble because ex_valid and all controls are forced low.
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_pc4   <= id_pc4;
         ex_rs    <= id_rs;
         ex_rt    <= id_rt;
         ex_rd    <= id_rd;
         ex_funct <= id_funct;

         // Explicit zeros keep X controls from the decoder out of EX.
         if (bubble) begin
            ex_regdst   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_valid    <= 1'b0;
         end else begin
            ex_regdst   <= id_regdst;
            ex_branch   <= id_branch;
            ex_memread  <= id_memread;
            ex_memtoreg <= id_memtoreg;
            ex_memwrite <= id_memwrite;
            ex_alusrc   <= id_alusrc;
            ex_regwrite <= id_regwrite;
            ex_aluop    <= id_aluop;
            ex_valid    <= 1'b1;
         end

         // Only hazard bubbles count; a squash is not a stall.
         if (stall && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall/bubble, source masks,
// flush priority, counter saturation (second instance with CNT_W=2) and
// asynchronous reset while stalled.
module tb_id_ex_stage;

   localparam int unsigned DW = 32;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [5:0]    id_opcode;
   logic          id_regdst, id_branch, id_memread, id_memtoreg;
   logic          id_memwrite, id_alusrc, id_regwrite;
   logic [1:0]    id_aluop;
   logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic [5:0]    id_funct;

   logic          stall;
   logic          ex_regdst, ex_branch, ex_memread, ex_memtoreg;
   logic          ex_memwrite, ex_alusrc, ex_regwrite;
   logic [1:0]    ex_aluop;
   logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic [5:0]    ex_funct;
   logic          ex_valid;
   logic [15:0]   bubble_cnt;

   logic          s_stall;
   logic          s_regdst, s_branch, s_memread, s_memtoreg;
   logic          s_memwrite, s_alusrc, s_regwrite;
   logic [1:0]    s_aluop;
   logic [DW-1:0] s_rd1, s_rd2, s_imm, s_pc4;
   logic [4:0]    s_rs, s_rt, s_rd;
   logic [5:0]    s_funct;
   logic          s_valid;
   logic [1:0]    s_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_opcode(id_opcode),
      .id_regdst(id_regdst), .id_branch(id_branch), .id_memread(id_memread),
      .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
      .id_regwrite(id_regwrite), .id_aluop(id_aluop), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .stall(stall), .ex_regdst(ex_regdst), .ex_branch(ex_branch),
      .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
      .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
   );

   id_ex_stage #(.DATA_W(DW), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_opcode(id_opcode),
      .id_regdst(id_regdst), .id_branch(id_branch), .id_memread(id_memread),
      .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
      .id_regwrite(id_regwrite), .id_aluop(id_aluop), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .stall(s_stall), .ex_regdst(s_regdst), .ex_branch(s_branch),
      .ex_memread(s_memread), .ex_memtoreg(s_memtoreg), .ex_memwrite(s_memwrite),
      .ex_alusrc(s_alusrc), .ex_regwrite(s_regwrite), .ex_aluop(s_aluop),
      .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_pc4(s_pc4),
      .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
      .ex_valid(s_valid), .bubble_cnt(s_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive an ID-stage instruction with the decoder controls a MIPS main
   // decoder would produce for that opcode.
   task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [DW-1:0] rd1,
                        input logic [DW-1:0] rd2);
      id_opcode = op;
      id_rs = rs; id_rt = rt; id_rd = rd;
      id_rd1 = rd1; id_rd2 = rd2;
      id_imm = {27'd0, rd}; id_pc4 = 32'h0000_0100; id_funct = 6'h20;
      {id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc,
       id_regwrite} = 7'b0;
      id_aluop = 2'b00;
      case (op)
         OP_R:   begin id_regdst = 1'b1; id_regwrite = 1'b1; id_aluop = 2'b10; end
         OP_LW:  begin id_memread = 1'b1; id_memtoreg = 1'b1; id_alusrc = 1'b1;
                       id_regwrite = 1'b1; end
         OP_SW:  begin id_memwrite = 1'b1; id_alusrc = 1'b1; end
         OP_BEQ: begin id_branch = 1'b1; id_aluop = 2'b01; end
         default: ;
      endcase
   endtask

   initial begin
      // Reset held with random ID inputs and a running clock.
      drive(OP_LW, 5'd8, 5'd8, 5'd8, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         id_rd1 = $urandom; id_rd2 = $urandom; id_rs = 5'($urandom); id_rt = 5'($urandom);
         step();
      end
      check_eq("rst_regwrite", ex_regwrite, 0);
      check_eq("rst_memread", ex_memread, 0);
      check_eq("rst_rd1", ex_rd1, 0);
      check_eq("rst_aluop", ex_aluop, 0);
      check_eq("rst_valid", ex_valid, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_cnt", bubble_cnt, 0);

      // Release away from an edge, then a plain R-type.
      rst_n = 1'b1;
      drive(OP_R, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7);
      step();
      check_eq("r_regwrite", ex_regwrite, 1);
      check_eq("r_aluop", ex_aluop, 2'b10);
      check_eq("r_rd1", ex_rd1, 32'h5);
      check_eq("r_rd2", ex_rd2, 32'h7);
      check_eq("r_rd", ex_rd, 5'd3);
      check_eq("r_valid", ex_valid, 1);
      check_eq("r_stall", stall, 0);

      // Load-use on rt.
      drive(OP_LW, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0);
      step();
      check_eq("lw_memread", ex_memread, 1);
      drive(OP_R, 5'd9, 5'd8, 5'd4, 32'h11, 32'h22);
      #1;
      check_eq("lu_stall", stall, 1);
      step();
      check_eq("lu_bub_valid", ex_valid, 0);
      check_eq("lu_bub_regwrite", ex_regwrite, 0);
      check_eq("lu_bub_memread", ex_memread, 0);
      check_eq("lu_bub_regdst", ex_regdst, 0);
      check_eq("lu_bub_aluop", ex_aluop, 0);
      check_eq("lu_cnt", bubble_cnt, 1);
      check_eq("lu_cnt_sat", s_cnt, 1);
      check_eq("lu_stall_drop", stall, 0);
      step();
      check_eq("lu_adv_valid", ex_valid, 1);
      check_eq("lu_adv_regdst", ex_regdst, 1);
      check_eq("lu_adv_rs", ex_rs, 5'd9);
      check_eq("lu_adv_cnt", bubble_cnt, 1);

      // Source masks against lw rt=8 in EX.
      drive(OP_LW, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0);
      step();
      drive(OP_LW, 5'd3, 5'd8, 5'd0, 32'h0, 32'h0);
      #1 check_eq("mask_lw_rt", stall, 0);
      drive(OP_LW, 5'd8, 5'd4, 5'd0, 32'h0, 32'h0);
      #1 check_eq("lw_rs_dep", stall, 1);
      drive(OP_SW, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0);
      #1 check_eq("sw_rt_dep", stall, 1);
      drive(OP_J, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0);
      #1 check_eq("mask_j_rs", stall, 0);
      drive(OP_LW, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0);
      step();
      drive(OP_R, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0);
      #1 check_eq("mask_zero", stall, 0);

      // Flush beats hazard.
      drive(OP_LW, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0);
      step();
      drive(OP_BEQ, 5'd8, 5'd2, 5'd0, 32'h0, 32'h0);
      flush = 1'b1;
      #1 check_eq("flush_stall", stall, 0);
      step();
      flush = 1'b0;
      check_eq("flush_valid", ex_valid, 0);
      check_eq("flush_branch", ex_branch, 0);
      check_eq("flush_cnt", bubble_cnt, 1);

      // Four more hazard bubbles: 16-bit counter 2..5, 2-bit counter 2,3,3,3.
      for (int i = 0; i < 4; i++) begin
         drive(OP_LW, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0);
         step();
         drive(OP_R, 5'd8, 5'd0, 5'd6, 32'h0, 32'h0);
         step();
         check_eq("sat_cnt16", bubble_cnt, 64'(i + 2));
         check_eq("sat_cnt2", s_cnt, (i == 0) ? 64'd2 : 64'd3);
      end

      // Asynchronous reset while stalled.
      drive(OP_LW, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0);
      step();
      drive(OP_R, 5'd8, 5'd0, 5'd6, 32'h0, 32'h0);
      #1 check_eq("ar_pre_stall", stall, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("ar_stall", stall, 0);
      check_eq("ar_memread", ex_memread, 0);
      check_eq("ar_regwrite", ex_regwrite, 0);
      check_eq("ar_rt", ex_rt, 0);
      check_eq("ar_valid", ex_valid, 0);
      check_eq("ar_cnt", bubble_cnt, 0);
      check_eq("ar_cnt_sat", s_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
